// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  reg_scoreboard_if
//  Decode / writeback / flush signal bundle between the pipeline and the
//  destination-register scoreboard.
//  Revision: 1.0  initial release
// ============================================================================
interface reg_scoreboard_if #(
  parameter int NREG = 32
);
  logic            id_valid;
  logic [4:0]      id_rn;
  logic [4:0]      id_rm;
  logic            id_use_rn;
  logic            id_use_rm;
  logic [4:0]      id_rd;
  logic            id_rd_we;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            stall;
  logic            issue;
  logic [NREG-1:0] busy_vec;
  logic            err;

  // Pipeline side: presents decode/writeback traffic, observes stall state.
  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_rd_we,
    output wb_valid, wb_rd, flush,
    input  stall, issue, busy_vec, err
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_rd_we,
    input  wb_valid, wb_rd, flush,
    output stall, issue, busy_vec, err
  );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  reg_scoreboard
//  Per-register pending-write counters for the segmented ARMv8 pipeline.
//  Raises a decode stall on a read-after-write hazard or when the
//  destination's pending counter is saturated. XZR is never tracked.
//  Revision: 1.0  initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NREG   = 32,
  parameter int CW     = 2,
  parameter int ZR_IDX = 31
) (
  input wire               clk,
  input wire               Reset,
  reg_scoreboard_if.slave  bus
);

  localparam logic [4:0]    ZR      = 5'(ZR_IDX);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt [NREG];
  logic          err_flag;

  logic busy_rn;
  logic busy_rm;
  logic hazard;
  logic full;
  logic inc;
  logic dec;
  logic underflow;

  // Hazard and saturation detection from registered counts only (no wb bypass).
  always_comb begin
    busy_rn   = (cnt[bus.id_rn] != '0) && (bus.id_rn != ZR);
    busy_rm   = (cnt[bus.id_rm] != '0) && (bus.id_rm != ZR);
    hazard    = (bus.id_use_rn && busy_rn) || (bus.id_use_rm && busy_rm);
    full      = bus.id_rd_we && (bus.id_rd != ZR) && (cnt[bus.id_rd] == CNT_MAX);
    inc       = bus.issue && bus.id_rd_we && (bus.id_rd != ZR);
    dec       = bus.wb_valid && (bus.wb_rd != ZR) && (cnt[bus.wb_rd] != '0);
    underflow = bus.wb_valid && (bus.wb_rd != ZR) && (cnt[bus.wb_rd] == '0);
  end

  assign bus.stall = bus.id_valid && !bus.flush && (hazard || full);
  assign bus.issue = bus.id_valid && !bus.flush && !bus.stall;
  assign bus.err   = err_flag;

  // Busy bits come straight from the counter flops; XZR is forced idle.
  for (genvar r = 0; r < NREG; r++) begin : g_busy
    if (r == ZR_IDX) begin : g_zr
      assign bus.busy_vec[r] = 1'b0;
    end else begin : g_reg
      assign bus.busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Counter and sticky-error update: reset, then flush, then inc/dec.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      err_flag <= 1'b0;
    end else if (bus.flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        // Simultaneous inc and dec on one register cancel out.
        if (inc && (bus.id_rd == 5'(r)) && !(dec && (bus.wb_rd == 5'(r)))) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec && (bus.wb_rd == 5'(r)) && !(inc && (bus.id_rd == 5'(r)))) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (underflow) begin
        err_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  tb_reg_scoreboard
//  Self-checking bench: a reference model of the pending-write counters
//  predicts stall/issue each cycle and pushes the expected post-edge
//  busy_vec/err onto a queue that is popped after the edge.
//  Revision: 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(32)) bus ();

  reg_scoreboard #(.NREG(32), .CW(2), .ZR_IDX(31)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] busy;
    logic        err;
  } st_t;

  st_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  mcnt[32];
  bit  merr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mbusy(input logic [4:0] r);
    return (mcnt[r] != 0) && (r != 5'd31);
  endfunction

  function automatic logic [31:0] mbusy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = mbusy(5'(r));
    return v;
  endfunction

  task automatic drv(input bit v, input logic [4:0] rn, input bit urn,
                     input logic [4:0] rm, input bit urm,
                     input logic [4:0] rd, input bit we,
                     input bit wv, input logic [4:0] wrd,
                     input bit fl, input bit rs);
    bus.id_valid  = v;
    bus.id_rn     = rn;
    bus.id_use_rn = urn;
    bus.id_rm     = rm;
    bus.id_use_rm = urm;
    bus.id_rd     = rd;
    bus.id_rd_we  = we;
    bus.wb_valid  = wv;
    bus.wb_rd     = wrd;
    bus.flush     = fl;
    Reset         = rs;
  endtask

  // One clock: check combinational outputs, advance model, check state after edge.
  task automatic tick(input string tag);
    bit  hz, full, es, ei, inc, dec, unf;
    st_t e, o;
    #2;
    hz   = (bus.id_use_rn && mbusy(bus.id_rn)) || (bus.id_use_rm && mbusy(bus.id_rm));
    full = bus.id_rd_we && (bus.id_rd != 5'd31) && (mcnt[bus.id_rd] == 3);
    es   = bus.id_valid && !bus.flush && (hz || full);
    ei   = bus.id_valid && !bus.flush && !es;
    check_val({tag, ".stall"}, 32'(bus.stall), 32'(es));
    check_val({tag, ".issue"}, 32'(bus.issue), 32'(ei));
    @(posedge clk);
    if (Reset) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      merr = 1'b0;
    end else if (bus.flush) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
    end else begin
      inc = ei && bus.id_rd_we && (bus.id_rd != 5'd31);
      dec = bus.wb_valid && (bus.wb_rd != 5'd31) && (mcnt[bus.wb_rd] != 0);
      unf = bus.wb_valid && (bus.wb_rd != 5'd31) && (mcnt[bus.wb_rd] == 0);
      if (inc && dec && (bus.id_rd == bus.wb_rd)) begin
        // net zero
      end else begin
        if (inc) mcnt[bus.id_rd] = mcnt[bus.id_rd] + 1;
        if (dec) mcnt[bus.wb_rd] = mcnt[bus.wb_rd] - 1;
      end
      if (unf) merr = 1'b1;
    end
    e.busy = mbusy_vec();
    e.err  = merr;
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    check_val({tag, ".busy"}, bus.busy_vec, o.busy);
    check_val({tag, ".err"}, 32'(bus.err), 32'(o.err));
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("rst0");
    tick("rst1");

    // RAW hazard on x5; release one cycle after the writeback.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); tick("iss5");
    check_val("busy5", bus.busy_vec, 32'h0000_0020);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick("haz5");
    drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0); tick("wb5");
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick("rel5");

    // XZR is never tracked and never underflows.
    drv(1, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0); tick("iss31");
    drv(1, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0); tick("rd31");
    drv(0, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0); tick("wb31");

    // Saturate x7, fourth writer stalls on full until one retires.
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    tick("f7a"); tick("f7b"); tick("f7c"); tick("f7full");
    drv(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0); tick("f7wb");
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); tick("f7iss");
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    tick("d7a"); tick("d7b"); tick("d7c");

    // Simultaneous issue and writeback to x9.
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); tick("iss9");
    drv(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0); tick("same9");
    check_val("busy9", 32'(bus.busy_vec[9]), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); tick("d9");

    // Flush discards counts and ignores that cycle's issue and writeback.
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); tick("i3a"); tick("i3b");
    drv(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0); tick("i12");
    drv(1, 3, 1, 0, 0, 3, 1, 1, 3, 1, 0); tick("flush");
    check_val("flushbusy", bus.busy_vec, 32'h0);

    // Sticky underflow error: survives flush, cleared by reset.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0); tick("unf4");
    check_val("err1", 32'(bus.err), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("errfl");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick("errrst");

    // Reset in the middle of a stall releases it next cycle.
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0); tick("iss6");
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick("rststall");
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick("postrst");

    // Flush together with reset behaves as reset.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0); tick("unf2");
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); tick("iss2");
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("flrst");

    // Random traffic over a small register set to force collisions.
    for (int i = 0; i < 300; i++) begin
      drv($urandom_range(0, 3) != 0, pick(), $urandom_range(0, 1) == 1,
          pick(), $urandom_range(0, 1) == 1, pick(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, pick(), $urandom_range(0, 40) == 0,
          $urandom_range(0, 80) == 0);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
